mealy_pattern_detector: RTL
===========================

MEALY_PATTERN_DETECTOR -- requirements
Module: mealy_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PAT_RST, default 4'b0111: pattern value loaded at reset; PAT_W bits wide; MSB is the oldest bit.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset; synchronous, active-high.
REQ-006 Port in, input, 1: serial data bit.
REQ-007 Port in_valid, input, 1: qualifies in; when low, in is ignored and no state changes.
REQ-008 Port pat_load, input, 1: loads a new pattern from pat_in.
REQ-009 Port pat_in, input, PAT_W: new pattern value; MSB is the oldest bit.
REQ-010 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 Port out, output, 1: Mealy match flag; combinational from state and the current in.
REQ-012 Port match_cnt, output, CNT_W: count of detected matches.

Function
REQ-013 The block SHALL hold these registers: pattern (PAT_W), history (PAT_W-1, newest bit in the LSB), fill (counts accepted bits, saturates at PAT_W-1), and match_cnt.
REQ-014 out SHALL be 1 in the same cycle iff all of the following hold: in_valid=1, pat_load=0, rst=0, fill==PAT_W-1, and {history, in}==pattern.
REQ-015 There SHALL be zero-cycle latency from the final pattern bit on in to out, with no register on out.
REQ-016 On an accepted bit (in_valid=1, pat_load=0) the block SHALL shift history left with in entering the LSB.
REQ-017 On an accepted bit, fill SHALL increment, saturating at PAT_W-1.
REQ-018 When out=1 and overlap=1, fill SHALL stay at PAT_W-1, so that a match may share bits with the next match.
REQ-019 When out=1 and overlap=0, fill SHALL clear to 0 and history SHALL clear, so that the next match needs PAT_W fresh bits.
REQ-020 overlap SHALL be sampled every cycle; changing it affects only the decision at the next match.
REQ-021 pat_load=1 SHALL, on that edge, write pat_in into pattern and clear history and fill.
REQ-022 When pat_load=1 and in_valid=1 in the same cycle, pat_load SHALL win: the bit is discarded and out=0.
REQ-023 When out=1, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1 (no wrap).
REQ-024 match_cnt SHALL NOT be cleared by pat_load.
REQ-025 When in_valid=0, history, fill and match_cnt SHALL hold, and out SHALL be 0.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set pattern=PAT_RST, history=0, fill=0 and match_cnt=0.
REQ-027 While rst=1, out SHALL be 0.
REQ-028 rst SHALL take priority over pat_load and in_valid.
REQ-029 rst asserted mid-sequence SHALL discard partial progress; detection after reset requires PAT_W new bits.

Configuration
REQ-030 With macro MEALY_MATCH_CNT_EN defined, match_cnt SHALL be implemented as specified in REQ-023 and REQ-024.
REQ-031 With MEALY_MATCH_CNT_EN undefined, match_cnt SHALL be tied to 0 and no counter flops SHALL be inferred.
REQ-032 out behaviour SHALL be identical with and without MEALY_MATCH_CNT_EN.

Verification
REQ-033 Default pattern: PAT_W=4, overlap=1, rst then in_valid=1, in=0,1,1,1 -> out=1 only in the 4th cycle, combinationally with in=1; match_cnt=1 next cycle.
REQ-034 Overlap mode: pattern 4'b1010 loaded, overlap=1, in=1,0,1,0,1,0 -> out=1 on bits 4 and 6; match_cnt=2.
REQ-035 Non-overlap mode: same stream with overlap=0 -> out=1 on bit 4 only; match_cnt=1.
REQ-036 Load collision and gaps: pat_load=1 with pat_in=4'b1100 and in_valid=1 in the same cycle -> bit ignored and out=0; then in=1,1,0,0 interleaved with in_valid=0 gaps -> out=1 only on the final accepted 0.
REQ-037 Reset mid-sequence: in=0,1,1, then rst for 1 cycle, then in=1 -> out=0; then in=0,1,1,1 -> out=1 on the last bit.
REQ-038 Counter saturation: CNT_W=2, 5 overlapping matches -> match_cnt holds at 3.
REQ-039 Counter compiled out: MEALY_MATCH_CNT_EN undefined -> match_cnt=0 throughout while out is unchanged.

Source files
------------

// File: rtl/mealy_pattern_detector.sv
// Serial Mealy pattern detector with runtime-loadable pattern and overlap select.
// out is combinational (zero latency); match_cnt exists only with MEALY_MATCH_CNT_EN defined.
module mealy_pattern_detector #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PAT_RST = 4'b0111,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] window;
    logic             accept;

    assign window = {hist_q, in};
    assign accept = in_valid && !pat_load && !rst;
    assign out    = accept && (fill_q == FILL_MAX) && (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (out && !overlap) begin
                // Non-overlapping: the next match must be built from fresh bits only.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_RST;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef MEALY_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
